// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial bit-sequence generator, MSB of the active field first, with repeat passes.
// Optional macro SEQ_GEN_GAP_EN inserts one idle-level gap cycle between passes.
module seq_gen #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int RPT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [RPT_W-1:0] rpt,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_GEN_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_index;
    logic [RPT_W-1:0] r_pass;
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W-1:0] w_first_idx;
    logic [LEN_W-1:0] w_reload_idx;
    logic [LEN_W-1:0] w_next_idx;
    logic             w_last_bit;

    assign w_len_eff    = (len > WIDTH_L) ? WIDTH_L : len;
    assign w_first_idx  = w_len_eff - LEN_W'(1);
    assign w_reload_idx = r_len - LEN_W'(1);
    assign w_next_idx   = r_index - LEN_W'(1);
    assign w_last_bit   = (r_index == '0);

    // Shift rather than index so the LEN_W-bit index never has to match the pattern's index width.
    function automatic logic bit_at(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] idx);
        logic [WIDTH-1:0] shifted;
        shifted = pat >> idx;
        return shifted[0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_index   <= '0;
            r_pass    <= '0;
            r_out     <= 1'b1;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (abort && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_out   <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort && (len != '0)) begin
                        r_pattern <= pattern;
                        r_len     <= w_len_eff;
                        r_index   <= w_first_idx;
                        r_pass    <= rpt;
                        r_out     <= bit_at(pattern, w_first_idx);
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!w_last_bit) begin
                        r_index <= w_next_idx;
                        r_out   <= bit_at(r_pattern, w_next_idx);
                    end else if (r_pass != '0) begin
                        r_pass <= r_pass - RPT_W'(1);
`ifdef SEQ_GEN_GAP_EN
                        r_state <= ST_GAP;
                        r_out   <= 1'b1;
                        r_valid <= 1'b0;
`else
                        r_index <= w_reload_idx;
                        r_out   <= bit_at(r_pattern, w_reload_idx);
`endif
                    end else begin
                        r_state <= ST_DONE;
                        r_out   <= 1'b1;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                ST_GAP: begin
                    r_index <= w_reload_idx;
                    r_out   <= bit_at(r_pattern, w_reload_idx);
                    r_valid <= 1'b1;
                    r_state <= ST_SEND;
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= 1'b1;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - directed self-checking bench for seq_gen.
module tb_seq_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  rpt;
    logic        out;
    logic        valid;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    seq_gen #(.WIDTH(16), .LEN_W(5), .RPT_W(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .len     (len),
        .rpt     (rpt),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_out, input logic e_valid,
                              input logic e_busy, input logic e_done);
        check({tag, ".out"},   {31'd0, out},   {31'd0, e_out});
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
        check({tag, ".busy"},  {31'd0, busy},  {31'd0, e_busy});
        check({tag, ".done"},  {31'd0, done},  {31'd0, e_done});
    endtask

    // Present inputs, pulse start across one edge; returns in the first output cycle.
    task automatic start_run(input logic [15:0] pat, input logic [4:0] ln, input logic [3:0] rp,
                             input logic keep_start);
        pattern = pat;
        len     = ln;
        rpt     = rp;
        start   = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        pattern = ~pat;
        len     = 5'd1;
        rpt     = 4'd0;
    endtask

    // Checks every cycle of a run already in its first output cycle, through the return to idle.
    task automatic expect_run(input string tag, input logic [15:0] pat, input int leff, input int rp);
        for (int p = 0; p <= rp; p++) begin
            for (int i = leff - 1; i >= 0; i--) begin
                check_outs($sformatf("%s.p%0d.b%0d", tag, p, i), pat[i], 1'b1, 1'b1, 1'b0);
                tick();
            end
`ifdef SEQ_GEN_GAP_EN
            if (p < rp) begin
                check_outs($sformatf("%s.gap%0d", tag, p), 1'b1, 1'b0, 1'b1, 1'b0);
                tick();
            end
`endif
        end
        check_outs({tag, ".done"}, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check_outs({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        rpt     = '0;

        repeat (3) tick();
        check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();
        check_outs("idle_after_reset", 1'b1, 1'b0, 1'b0, 1'b0);

        // 16'h000A, len 4: bits 1,0,1,0 then done, then idle
        start_run(16'h000A, 5'd4, 4'd0, 1'b0);
        check_outs("a.c1", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("a.c2", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("a.c3", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("a.c4", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("a.c5", 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check_outs("a.c6", 1'b1, 1'b0, 1'b0, 1'b0);

        start_run(16'h0000, 5'd4, 4'd2, 1'b0);
        expect_run("zeros", 16'h0000, 4, 2);

        start_run(16'h0006, 5'd3, 4'd1, 1'b0);
        expect_run("rpt1", 16'h0006, 3, 1);

        start_run(16'h0001, 5'd1, 4'd0, 1'b0);
        expect_run("len1", 16'h0001, 1, 0);

        // len=0 is ignored
        start_run(16'hFFFF, 5'd0, 4'd3, 1'b0);
        check_outs("len0.c1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("len0.c2", 1'b1, 1'b0, 1'b0, 1'b0);

        start_run(16'hA5C3, 5'd31, 4'd0, 1'b0);
        expect_run("clamp", 16'hA5C3, 16, 0);

        // start held throughout: one run, then a new one only from idle
        start_run(16'h0002, 5'd2, 4'd0, 1'b1);
        expect_run("held", 16'h0002, 2, 0);
        pattern = 16'h0002;
        len     = 5'd2;
        tick();
        start = 1'b0;
        check_outs("held.rerun", 1'b1, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("held.abort", 1'b1, 1'b0, 1'b0, 1'b0);

        // abort on the 3rd bit of 1011_0100
        start_run(16'h00B4, 5'd8, 4'd0, 1'b0);
        check_outs("ab.c1", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("ab.c2", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("ab.c3", 1'b1, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("ab.c4", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("ab.nodone%0d", k), {31'd0, done}, 32'd0);
        end
        start_run(16'h000A, 5'd4, 4'd0, 1'b0);
        expect_run("after_abort", 16'h000A, 4, 0);

        // abort and start together in idle: start is not accepted
        pattern = 16'h00FF;
        len     = 5'd8;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_outs("abort_start", 1'b1, 1'b0, 1'b0, 1'b0);

        // reset during the 2nd pass of 101
        start_run(16'h0005, 5'd3, 4'd1, 1'b0);
        repeat (3) tick();
`ifdef SEQ_GEN_GAP_EN
        tick();
`endif
        check_outs("rst.p2b2", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("rst.p2b1", 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst.async", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check_outs("rst.idle", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
